// File: rtl/bram_dot_product_if.sv
// Command, status and dual-port memory read bus of bram_dot_product.
// The sat status line exists only when DOT_SAT16_EN is defined.
interface bram_dot_product_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 2*DATA_W + ADDR_W
);
    logic              start;
    logic [ADDR_W-1:0] base_x;
    logic [ADDR_W-1:0] base_y;
    logic [ADDR_W:0]   len;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              we_a;
    logic              we_b;
    logic [DATA_W-1:0] data_out_a;
    logic [DATA_W-1:0] data_out_b;
    logic [ACC_W-1:0]  result;
    logic              busy;
    logic              done;
`ifdef DOT_SAT16_EN
    logic              sat;

    modport slave (
        input  start, base_x, base_y, len, data_out_a, data_out_b,
        output addr_a, addr_b, we_a, we_b, result, busy, done, sat
    );
    modport master (
        output start, base_x, base_y, len, data_out_a, data_out_b,
        input  addr_a, addr_b, we_a, we_b, result, busy, done, sat
    );
`else
    modport slave (
        input  start, base_x, base_y, len, data_out_a, data_out_b,
        output addr_a, addr_b, we_a, we_b, result, busy, done
    );
    modport master (
        output start, base_x, base_y, len, data_out_a, data_out_b,
        input  addr_a, addr_b, we_a, we_b, result, busy, done
    );
`endif
endinterface

// File: rtl/bram_dot_product.sv
// Signed dot product of two vectors streamed from a dual-port BRAM.
// Define DOT_SAT16_EN to clamp the result to 16 bits and add the sat pulse.
module bram_dot_product #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 2*DATA_W + ADDR_W
) (
    input logic             clk,
    input logic             rst,
    bram_dot_product_if.slave bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]               state;
    logic [ADDR_W-1:0]        addr_a;
    logic [ADDR_W-1:0]        addr_b;
    logic [ADDR_W:0]          len_r;
    logic [ADDR_W:0]          cnt;
    logic                     valid;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
    logic signed [ACC_W-1:0]  final_val;
    logic signed [ACC_W-1:0]  result;
    logic signed [2*DATA_W-1:0] prod;
    logic                     sat_hit;

    always_comb begin
        prod     = $signed(bus.data_out_a) * $signed(bus.data_out_b);
        acc_next = acc;
        if (valid)
            acc_next = acc + ACC_W'(prod);
    end

`ifdef DOT_SAT16_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);
    logic sat_r;

    always_comb begin
        final_val = acc_next;
        sat_hit   = 1'b0;
        if (acc_next > SAT_MAX) begin
            final_val = SAT_MAX;
            sat_hit   = 1'b1;
        end else if (acc_next < SAT_MIN) begin
            final_val = SAT_MIN;
            sat_hit   = 1'b1;
        end
    end
`else
    always_comb begin
        final_val = acc_next;
        sat_hit   = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            addr_a <= '0;
            addr_b <= '0;
            len_r  <= '0;
            cnt    <= '0;
            valid  <= 1'b0;
            acc    <= '0;
            result <= '0;
`ifdef DOT_SAT16_EN
            sat_r  <= 1'b0;
`endif
        end else begin
            // valid trails the address issue by one cycle, matching the BRAM read latency
            valid <= (state == FETCH);
            acc   <= acc_next;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.len != '0) begin
                            addr_a <= bus.base_x;
                            addr_b <= bus.base_y;
                            len_r  <= bus.len;
                            cnt    <= '0;
                            acc    <= '0;
                            state  <= FETCH;
                        end else begin
                            result <= '0;
`ifdef DOT_SAT16_EN
                            sat_r  <= 1'b0;
`endif
                            state  <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (cnt == len_r - (ADDR_W+1)'(1)) begin
                        state <= DRAIN;
                    end else begin
                        cnt    <= cnt + (ADDR_W+1)'(1);
                        addr_a <= addr_a + ADDR_W'(1);
                        addr_b <= addr_b + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    // the last product lands in acc on this same edge, so take it from acc_next
                    result <= final_val;
`ifdef DOT_SAT16_EN
                    sat_r  <= sat_hit;
`endif
                    state  <= DONE;
                end
                default: begin
`ifdef DOT_SAT16_EN
                    sat_r <= 1'b0;
`endif
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.addr_a = addr_a;
    assign bus.addr_b = addr_b;
    assign bus.we_a   = 1'b0;
    assign bus.we_b   = 1'b0;
    assign bus.result = result;
    assign bus.busy   = (state == FETCH) || (state == DRAIN);
    assign bus.done   = (state == DONE);
`ifdef DOT_SAT16_EN
    assign bus.sat    = sat_r;
`else
    logic unused_sat;
    assign unused_sat = sat_hit;
`endif
endmodule

// File: tb/tb_bram_dot_product.sv
// Self-checking bench for bram_dot_product with a behavioural BRAM and dot-product model.
module tb_bram_dot_product;
    localparam int DW = 8;
    localparam int AW = 10;
    localparam int CW = 2*DW + AW;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bram_dot_product_if #(.DATA_W(DW), .ADDR_W(AW), .ACC_W(CW)) bus ();

    bram_dot_product #(.DATA_W(DW), .ADDR_W(AW), .ACC_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic signed [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_a, rd_b;
    always @(posedge clk) begin
        rd_a <= mem[bus.addr_a];
        rd_b <= mem[bus.addr_b];
    end
    assign bus.data_out_a = rd_a;
    assign bus.data_out_b = rd_b;

    int n_checks = 0;
    int n_fail = 0;
    int done_count = 0;
    int last_a = 0;
    int last_b = 0;
    always @(posedge clk) if (bus.done) done_count++;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    function automatic longint dot_ref(input int bx, input int by, input int ln);
        longint s = 0;
        for (int i = 0; i < ln; i++)
            s += longint'(mem[(bx + i) % DEPTH]) * longint'(mem[(by + i) % DEPTH]);
        return s;
    endfunction

    function automatic longint clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    task automatic fill(input int kind);
        case (kind)
            0: begin
                for (int i = 0; i < 4; i++) begin
                    mem[i]       = DW'(i + 1);
                    mem[100 + i] = DW'(i + 5);
                end
            end
            1: begin
                mem[1022] = -8'sd128;
                mem[1023] = -8'sd128;
                mem[0]    = 8'sd127;
                mem[1]    = -8'sd1;
            end
            2: for (int i = 0; i < DEPTH; i++) mem[i] = -8'sd128;
            3: for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            default: ;
        endcase
    endtask

    // One full operation; optionally re-pulses start during the done cycle, which must be ignored.
    task automatic run_op(input string tag, input int bx, input int by, input int ln,
                          input longint exp_res, input bit exp_sat, input bit poke_in_done);
        int cyc;
        bit addr_ok, busy_ok;
        logic [AW-1:0] ea, eb;
        @(negedge clk);
        bus.start = 1'b1;
        bus.base_x = AW'(bx);
        bus.base_y = AW'(by);
        bus.len = (AW+1)'(ln);
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        addr_ok = 1'b1;
        busy_ok = 1'b1;
        while (!bus.done && cyc < ln + 20) begin
            if (!bus.busy) busy_ok = 1'b0;
            if (cyc <= ln && (bus.addr_a != AW'(bx + cyc - 1) || bus.addr_b != AW'(by + cyc - 1)))
                addr_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        if (ln > 0) begin
            last_a = (bx + ln - 1) % DEPTH;
            last_b = (by + ln - 1) % DEPTH;
        end
        ea = AW'(last_a);
        eb = AW'(last_b);
        check({tag, " done"}, longint'(bus.done), 1);
        check({tag, " latency"}, cyc, (ln == 0) ? 1 : ln + 2);
        check({tag, " result"}, longint'($signed(bus.result)), exp_res);
`ifdef DOT_SAT16_EN
        check({tag, " sat"}, longint'(bus.sat), longint'(exp_sat));
`endif
        check({tag, " busy_at_done"}, longint'(bus.busy), 0);
        check({tag, " busy_during"}, longint'(busy_ok), 1);
        check({tag, " addr_seq"}, longint'(addr_ok), 1);
        check({tag, " addr_hold"}, longint'({bus.addr_a, bus.addr_b}), longint'({ea, eb}));
        if (poke_in_done) begin
            bus.start = 1'b1;
            bus.base_x = AW'(7);
            bus.len = (AW+1)'(3);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, " done_one_cycle"}, longint'(bus.done), 0);
        check({tag, " idle_after"}, longint'(bus.busy), 0);
`ifdef DOT_SAT16_EN
        check({tag, " sat_cleared"}, longint'(bus.sat), 0);
`endif
    endtask

    typedef struct {
        int fill;
        int bx;
        int by;
        int ln;
        longint exp_res;
        bit exp_sat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bus.start = 1'b0;
        bus.base_x = '0;
        bus.base_y = '0;
        bus.len = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        vecs[0] = '{0, 0, 100, 4, 70, 1'b0};
        vecs[1] = '{0, 0, 0, 4, 30, 1'b0};
        vecs[2] = '{0, 100, 3, 1, 20, 1'b0};
        vecs[3] = '{1, 1022, 0, 2, -16128, 1'b0};
`ifdef DOT_SAT16_EN
        vecs[4] = '{2, 0, 0, 1024, 32767, 1'b1};
`else
        vecs[4] = '{2, 0, 0, 1024, 16777216, 1'b0};
`endif
        vecs[5] = '{9, 0, 0, 0, 0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset result", longint'(bus.result), 0);
        check("reset busy", longint'(bus.busy), 0);
        check("reset done", longint'(bus.done), 0);
        check("reset addr", longint'({bus.addr_a, bus.addr_b}), 0);
        check("we constant", longint'({bus.we_a, bus.we_b}), 0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            fill(vecs[v].fill);
            run_op($sformatf("vec%0d", v), vecs[v].bx, vecs[v].by, vecs[v].ln,
                   vecs[v].exp_res, vecs[v].exp_sat, 1'b0);
        end

        for (int r = 0; r < 20; r++) begin
            int bx, by, ln;
            longint full, exp;
            if (r % 5 == 0) fill(3);
            bx = int'($urandom_range(0, DEPTH - 1));
            by = (r % 4 == 0) ? bx : int'($urandom_range(0, DEPTH - 1));
            ln = int'($urandom_range(0, 40));
            full = dot_ref(bx, by, ln);
`ifdef DOT_SAT16_EN
            exp = clamp16(full);
`else
            exp = full;
`endif
            run_op($sformatf("rnd%0d", r), bx, by, ln, exp, exp != full, r % 3 == 0);
        end

        // Abort: second start ignored while busy, reset mid-operation, no done pulse.
        begin
            int dc;
            longint e;
            fill(3);
            dc = done_count;
            @(negedge clk);
            bus.start = 1'b1;
            bus.base_x = AW'(10);
            bus.base_y = AW'(20);
            bus.len = (AW+1)'(8);
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(negedge clk);
            bus.start = 1'b1;
            bus.base_x = AW'(500);
            bus.len = (AW+1)'(1);
            @(posedge clk); #1;
            bus.start = 1'b0;
            check("abort second_start_ignored addr", longint'(bus.addr_a), 11);
            check("abort busy_before_rst", longint'(bus.busy), 1);
            @(posedge clk); #1;
            @(negedge clk);
            rst = 1'b1;
            @(posedge clk); #1;
            check("abort busy_after_rst", longint'(bus.busy), 0);
            check("abort done_after_rst", longint'(bus.done), 0);
            check("abort result_after_rst", longint'(bus.result), 0);
            check("abort addr_after_rst", longint'({bus.addr_a, bus.addr_b}), 0);
            rst = 1'b0;
            last_a = 0;
            last_b = 0;
            check("abort no_done_pulse", done_count, dc);
            e = dot_ref(5, 6, 1);
            run_op("post_rst", 5, 6, 1, e, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_dot_product.md
BRAM_DOT_PRODUCT -- requirements
Module: bram_dot_product

Interface
REQ-001 Parameter DATA_W, default 8, is the signed element width held in each memory word.
REQ-002 Parameter ADDR_W, default 10, is the memory address width (1024 words).
REQ-003 Parameter ACC_W, default 2*DATA_W+ADDR_W (26), is the accumulator and result width.
REQ-004 clk  input  1  sole clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 start  input  1  one-cycle request to begin a dot product.
REQ-007 base_x  input  ADDR_W  start address of vector X (read on port A).
REQ-008 base_y  input  ADDR_W  start address of vector Y (read on port B).
REQ-009 len  input  ADDR_W+1  element count, 0..1024.
REQ-010 addr_a, addr_b  output  ADDR_W  read addresses to the dual-port memory.
REQ-011 we_a, we_b  output  1  memory write enables, constant 0.
REQ-012 data_out_a, data_out_b  input  DATA_W  registered memory read data, valid one cycle after the address is sampled.
REQ-013 result  output  ACC_W  signed sum of X[i]*Y[i].
REQ-014 busy  output  1  high from the cycle after an accepted start until done.
REQ-015 done  output  1  one-cycle pulse; result valid from this cycle until the next accepted start.

Function
REQ-016 The FSM SHALL have the states IDLE, FETCH, DRAIN and DONE.
REQ-017 In IDLE, start=1 with len!=0 SHALL latch base_x, base_y and len, clear the accumulator and enter FETCH.
REQ-018 In IDLE, start=1 with len=0 SHALL clear result to 0 and enter DONE directly.
REQ-019 In FETCH, addr_a/addr_b SHALL present base_x+i / base_y+i for i = 0..len-1, one pair per cycle, with wrap modulo 2^ADDR_W.
REQ-020 After the last address pair, FETCH SHALL go to DRAIN for exactly one cycle, then to DONE.
REQ-021 A one-cycle data-valid pipeline tracking the address issue SHALL gate the accumulation: acc <= acc + sext(data_out_a)*sext(data_out_b), signed, full ACC_W width, with no overflow possible.
REQ-022 DONE SHALL last one cycle with done=1 and result=acc, then return to IDLE.
REQ-023 Latency from an accepted start to done SHALL be len+2 cycles (1 cycle when len=0).
REQ-024 start SHALL be ignored while busy=1 or in DONE.
REQ-025 len values above 1024 are outside the contract; only len[ADDR_W:0] <= 1024 SHALL be guaranteed.
REQ-026 X and Y ranges SHALL be allowed to overlap or be identical (for example, sum of squares).
REQ-027 addr_a/addr_b SHALL hold their last value outside FETCH.

Reset
REQ-028 rst=1 at a clock edge SHALL force IDLE, with result=0, busy=0, done=0, addr_a=addr_b=0, the accumulator cleared and the valid pipeline cleared.
REQ-029 rst asserted mid-operation SHALL abort the operation with no done pulse; a start in the first cycle after rst deasserts SHALL be accepted.

Configuration
REQ-030 With macro DOT_SAT16_EN defined, result SHALL be clamped to [-32768, 32767] when done is asserted, and an extra output sat (1 bit) SHALL pulse with done if clamping occurred; sat SHALL reset to 0.
REQ-031 With DOT_SAT16_EN undefined, result SHALL be the full-width ACC_W sum and no sat port SHALL exist.

Verification
REQ-032 Load mem[0..3]={1,2,3,4} and mem[100..103]={5,6,7,8}, then issue start with base_x=0, base_y=100, len=4 -> done on cycle 6 after start, result=70.
REQ-033 Load mem[1022]=-128, mem[1023]=-128, mem[0]=127 and mem[1]=-1, then issue start with base_x=1022, base_y=0, len=2 -> address wrap is exercised, result=-16256+128=-16128.
REQ-034 Fill all 1024 words with -128, then issue start with base_x=base_y=0, len=1024 -> result=16777216 (full width), or 32767 with sat=1 when DOT_SAT16_EN is defined.
REQ-035 Issue start with len=0 -> done on the next cycle, result=0, no FETCH addresses issued.
REQ-036 Issue start with len=8, pulse start again at cycle 3, and assert rst at cycle 5 -> the second start is ignored, busy drops to 0 and no done pulse occurs; a new start with len=1 after rst completes normally.
